// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//  Shared definitions for the E-stage multiply/divide unit: the MD_Ctrl
//  operation codes driven by decode and the default busy latencies.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_ctrl_e;

  // Cycles Busy stays high after a multiply / divide is accepted.
  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit
//  Multiply/divide unit in the E stage, parallel to the ALU. Owns the
//  architectural HI/LO registers. The result of mult/multu/div/divu is
//  computed combinationally on accept and parked in a pending register; a
//  down-counter models the multi-cycle latency and the pending value is
//  committed to HI/LO on the last busy cycle.
//
// Ports
//  clk      in   1   rising-edge clock
//  reset    in   1   synchronous, active-low reset
//  MD_Ctrl  in   4   operation code (md_ctrl_e)
//  Start    in   1   qualifies mult/multu/div/divu this cycle
//  Flush    in   1   suppresses this cycle's Start / mthi / mtlo
//  SrcA     in   32  rs operand
//  SrcB     in   32  rt operand
//  Busy     out  1   multi-cycle operation in flight (registered)
//  HI       out  32  architectural HI
//  LO       out  32  architectural LO
//  MD_res   out  32  mfhi -> HI, mflo -> LO, otherwise 0 (combinational)
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MD_Ctrl,
  input  logic        Start,
  input  logic        Flush,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_res
);

  localparam int CNT_W = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_wr;
  logic [31:0]      r_hi_p;
  logic [31:0]      r_lo_p;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic               w_busy;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_arith;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic signed [63:0] w_a64_s;
  logic signed [63:0] w_b64_s;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_b_sdiv;
  logic [31:0]        w_b_udiv;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;
  logic [31:0]        w_hi_next;
  logic [31:0]        w_lo_next;

  assign w_busy     = (r_cnt != '0);
  assign w_is_mul   = (MD_Ctrl == MD_MULT) || (MD_Ctrl == MD_MULTU);
  assign w_is_div   = (MD_Ctrl == MD_DIV)  || (MD_Ctrl == MD_DIVU);
  assign w_is_arith = w_is_mul || w_is_div;
  assign w_accept   = Start && !w_busy && !Flush && w_is_arith;

  // ---- operand / arithmetic stage (combinational) ----
  assign w_a_s    = SrcA;
  assign w_b_s    = SrcB;
  assign w_a64_s  = {{32{SrcA[31]}}, SrcA};
  assign w_b64_s  = {{32{SrcB[31]}}, SrcB};
  assign w_prod_s = w_a64_s * w_b64_s;
  assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  assign w_div_zero = (SrcB == 32'd0);
  assign w_div_ovf  = (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);

  // Substituting a divisor of 1 keeps the dividers free of X/overflow. For the
  // 0x80000000 / -1 case this also yields exactly the required LO=0x80000000,
  // HI=0; for divide-by-zero the result is discarded via r_pend_wr.
  assign w_b_sdiv = (w_div_zero || w_div_ovf) ? 32'sd1 : w_b_s;
  assign w_b_udiv = w_div_zero ? 32'd1 : SrcB;
  assign w_quot_s = w_a_s / w_b_sdiv;
  assign w_rem_s  = w_a_s % w_b_sdiv;
  assign w_quot_u = SrcA / w_b_udiv;
  assign w_rem_u  = SrcA % w_b_udiv;

  always_comb begin
    w_hi_next = '0;
    w_lo_next = '0;
    case (MD_Ctrl)
      MD_MULT:  {w_hi_next, w_lo_next} = w_prod_s;
      MD_MULTU: {w_hi_next, w_lo_next} = w_prod_u;
      MD_DIV: begin
        w_hi_next = w_rem_s;
        w_lo_next = w_quot_s;
      end
      MD_DIVU: begin
        w_hi_next = w_rem_u;
        w_lo_next = w_quot_u;
      end
      default: ;
    endcase
  end

  // ---- sequencing: busy counter and commit enable ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= w_is_mul ? MUL_CNT : DIV_CNT;
      r_pend_wr <= !(w_is_div && w_div_zero);
    end else if (w_busy) begin
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  // Pending result; only consumed while r_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi_p <= w_hi_next;
      r_lo_p <= w_lo_next;
    end
  end

  // ---- architectural HI/LO ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_cnt == CNT_W'(1)) && r_pend_wr) begin
      r_hi <= r_hi_p;
      r_lo <= r_lo_p;
    end else if (!w_busy && !Flush) begin
      if (MD_Ctrl == MD_MTHI) r_hi <= SrcA;
      if (MD_Ctrl == MD_MTLO) r_lo <= SrcA;
    end
  end

  assign Busy = w_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

  always_comb begin
    MD_res = '0;
    if (MD_Ctrl == MD_MFHI) MD_res = r_hi;
    if (MD_Ctrl == MD_MFLO) MD_res = r_lo;
  end

  // The hazard unit must hold these back while Busy; reaching here means a stall bug.
  a_start_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(Start && w_busy && w_is_arith))
    else $warning("mul_div_unit: Start while Busy ignored (hazard unit did not stall)");

  a_mt_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(w_busy && !Flush && ((MD_Ctrl == MD_MTHI) || (MD_Ctrl == MD_MTLO))))
    else $warning("mul_div_unit: mthi/mtlo while Busy ignored (hazard unit did not stall)");

endmodule
